// File: rtl/tetris_pkg.sv
// Shared types and defaults for the piece fall path.
// Holds the fall FSM state enum, clock rate and timer defaults.
package tetris_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_TICK,
      CHECK,
      LOCK_WAIT,
      LOCK
   } fall_state_t;

   localparam int unsigned CLK_HZ          = 50_000_000;
   localparam int unsigned LOCK_CYCLES_DEF = CLK_HZ / 2;
   localparam int unsigned MAX_RESETS_DEF  = 15;

   // Counter width for a count range of n values, never below 1 bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/lock_timer.sv
// Lock-delay down counter: load to CYCLES-1, decrement, zero flag.
// Ports: clk, rst_n, load, dec in; zero out (counter at 0).
module lock_timer
   import tetris_pkg::*;
#(
   parameter int unsigned CYCLES = LOCK_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic dec,
   output logic zero
);

   localparam int unsigned W = cnt_w(CYCLES);
   localparam logic [W-1:0] LOAD_VAL = W'(CYCLES - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = LOAD_VAL;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/piece_fall_ctrl.sv
// Gravity-tick consumer: fit handshake, one-row moves, lock delay.
// In: clk rst_n spawn_valid down_signal soft_drop_held piece_moved
//     fit_ack fit_ok [hard_drop with PIECE_FALL_HARD_DROP_EN].
// Out: fit_req move_down lock_piece gravity_restart busy drop_rows.
module piece_fall_ctrl
   import tetris_pkg::*;
#(
   parameter int unsigned LOCK_CYCLES = LOCK_CYCLES_DEF,
   parameter int unsigned MAX_RESETS  = MAX_RESETS_DEF,
   parameter int unsigned ROW_CNT_W   = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 spawn_valid,
   input  logic                 down_signal,
   input  logic                 soft_drop_held,
   input  logic                 piece_moved,
   input  logic                 fit_ack,
   input  logic                 fit_ok,
`ifdef PIECE_FALL_HARD_DROP_EN
   input  logic                 hard_drop,
`endif
   output logic                 fit_req,
   output logic                 move_down,
   output logic                 lock_piece,
   output logic                 gravity_restart,
   output logic                 busy,
   output logic [ROW_CNT_W-1:0] drop_rows
);

   localparam int unsigned RW = cnt_w(MAX_RESETS + 1);
   localparam logic [RW-1:0] RST_MAX = RW'(MAX_RESETS);

   fall_state_t          state_q, state_d;
   logic                 fit_req_q, fit_req_d;
   logic                 move_down_q, move_down_d;
   logic                 lock_piece_q, lock_piece_d;
   logic                 grav_rst_q, grav_rst_d;
   logic                 busy_q, busy_d;
   logic                 hard_q, hard_d;
   logic [ROW_CNT_W-1:0] drop_rows_q, drop_rows_d;
   logic [RW-1:0]        rst_cnt_q, rst_cnt_d;

   logic t_load;
   logic t_dec;
   logic t_zero;
   logic ack;
   logic hard_go;

`ifdef PIECE_FALL_HARD_DROP_EN
   assign hard_go = hard_drop;
`else
   assign hard_go = 1'b0;
`endif

   assign ack = fit_ack & fit_req_q;

   lock_timer #(
      .CYCLES(LOCK_CYCLES)
   ) u_lock_timer (
      .clk  (clk),
      .rst_n(rst_n),
      .load (t_load),
      .dec  (t_dec),
      .zero (t_zero)
   );

   always_comb begin
      state_d      = state_q;
      fit_req_d    = fit_req_q;
      move_down_d  = 1'b0;
      lock_piece_d = 1'b0;
      grav_rst_d   = 1'b0;
      hard_d       = hard_q;
      drop_rows_d  = drop_rows_q;
      rst_cnt_d    = rst_cnt_q;
      t_load       = 1'b0;
      t_dec        = 1'b0;
      unique case (state_q)
         IDLE: begin
            fit_req_d   = 1'b0;
            hard_d      = 1'b0;
            drop_rows_d = '0;
            rst_cnt_d   = '0;
            if (spawn_valid) begin
               state_d    = WAIT_TICK;
               grav_rst_d = 1'b1;
            end
         end
         WAIT_TICK: begin
            fit_req_d = 1'b0;
            if (hard_go) begin
               state_d   = CHECK;
               fit_req_d = 1'b1;
               hard_d    = 1'b1;
            // down_signal is still high while our restart pulse is
            // in flight; that stale level must not start a new check.
            end else if (down_signal && !grav_rst_q) begin
               state_d   = CHECK;
               fit_req_d = 1'b1;
            end
         end
         CHECK: begin
            if (ack) begin
               fit_req_d = 1'b0;
               if (fit_ok) begin
                  move_down_d = 1'b1;
                  if ((soft_drop_held || hard_q)
                      && (drop_rows_q != '1)) begin
                     drop_rows_d = drop_rows_q + 1'b1;
                  end
                  if (hard_q) begin
                     fit_req_d = 1'b1;
                  end else begin
                     grav_rst_d = 1'b1;
                     state_d    = WAIT_TICK;
                  end
               end else if (hard_q) begin
                  lock_piece_d = 1'b1;
                  hard_d       = 1'b0;
                  state_d      = LOCK;
               end else begin
                  t_load  = 1'b1;
                  state_d = LOCK_WAIT;
               end
            end
         end
         LOCK_WAIT: begin
            if (hard_go) begin
               state_d   = CHECK;
               fit_req_d = 1'b1;
               hard_d    = 1'b1;
            end else if (piece_moved && (rst_cnt_q < RST_MAX)) begin
               rst_cnt_d = rst_cnt_q + 1'b1;
               fit_req_d = 1'b1;
               state_d   = CHECK;
            end else if (t_zero) begin
               lock_piece_d = 1'b1;
               state_d      = LOCK;
            end else begin
               t_dec = 1'b1;
            end
         end
         LOCK: begin
            state_d = IDLE;
         end
         default: begin
            state_d   = IDLE;
            fit_req_d = 1'b0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         fit_req_q    <= 1'b0;
         move_down_q  <= 1'b0;
         lock_piece_q <= 1'b0;
         grav_rst_q   <= 1'b0;
         busy_q       <= 1'b0;
         hard_q       <= 1'b0;
         drop_rows_q  <= '0;
         rst_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         fit_req_q    <= fit_req_d;
         move_down_q  <= move_down_d;
         lock_piece_q <= lock_piece_d;
         grav_rst_q   <= grav_rst_d;
         busy_q       <= busy_d;
         hard_q       <= hard_d;
         drop_rows_q  <= drop_rows_d;
         rst_cnt_q    <= rst_cnt_d;
      end
   end

   assign fit_req         = fit_req_q;
   assign move_down       = move_down_q;
   assign lock_piece      = lock_piece_q;
   assign gravity_restart = grav_rst_q;
   assign busy            = busy_q;
   assign drop_rows       = drop_rows_q;

endmodule

// File: tb/tb_piece_fall_ctrl.sv
// Directed bench for piece_fall_ctrl with a pulse-event scoreboard.
// LOCK_CYCLES=4, MAX_RESETS=2; pulses checked against expected cycle.
module tb_piece_fall_ctrl;

   localparam logic [2:0] K_MD = 3'b100;
   localparam logic [2:0] K_LP = 3'b010;
   localparam logic [2:0] K_GR = 3'b001;

   typedef struct packed {
      logic [2:0]  kind;
      int unsigned cyc;
   } ev_t;

   logic       clk;
   logic       rst_n;
   logic       spawn_valid;
   logic       down_signal;
   logic       soft_drop_held;
   logic       piece_moved;
   logic       fit_ack;
   logic       fit_ok;
`ifdef PIECE_FALL_HARD_DROP_EN
   logic       hard_drop;
`endif
   logic       fit_req;
   logic       move_down;
   logic       lock_piece;
   logic       gravity_restart;
   logic       busy;
   logic [4:0] drop_rows;

   int unsigned cyc;
   int          checks;
   int          errors;
   int unsigned ack_cyc;
   int          exp_rows;
   ev_t         exp_q[$];

   piece_fall_ctrl #(
      .LOCK_CYCLES(4),
      .MAX_RESETS (2),
      .ROW_CNT_W  (5)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .spawn_valid    (spawn_valid),
      .down_signal    (down_signal),
      .soft_drop_held (soft_drop_held),
      .piece_moved    (piece_moved),
      .fit_ack        (fit_ack),
      .fit_ok         (fit_ok),
`ifdef PIECE_FALL_HARD_DROP_EN
      .hard_drop      (hard_drop),
`endif
      .fit_req        (fit_req),
      .move_down      (move_down),
      .lock_piece     (lock_piece),
      .gravity_restart(gravity_restart),
      .busy           (busy),
      .drop_rows      (drop_rows)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [2:0] k, input int unsigned c);
      ev_t e;
      e.kind = k;
      e.cyc  = c;
      exp_q.push_back(e);
   endtask

   // Any pulse, or a due expectation, is one scoreboard comparison.
   always @(negedge clk) begin
      ev_t o;
      ev_t e;
      o.kind = {move_down, lock_piece, gravity_restart};
      o.cyc  = cyc;
      if (o.kind != 3'b000 ||
          (exp_q.size() > 0 && exp_q[0].cyc <= cyc)) begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
         end else begin
            e.kind = 3'b000;
            e.cyc  = 0;
         end
         checks++;
         assert (o === e) else begin
            errors++;
            $error("FAIL pulse got kind=%b cyc=%0d want kind=%b cyc=%0d",
                   o.kind, o.cyc, e.kind, e.cyc);
         end
      end
   end

   task automatic spawn();
      @(negedge clk);
      spawn_valid = 1'b1;
      push(K_GR, cyc + 1);
      @(negedge clk);
      spawn_valid = 1'b0;
      chk("busy_spawn", {31'd0, busy}, 32'd1);
   endtask

   task automatic fall(input int wait_n, input bit ok);
      @(negedge clk);
      @(negedge clk);
      down_signal = 1'b1;
      @(negedge clk);
      down_signal = 1'b0;
      chk("req_rise", {31'd0, fit_req}, 32'd1);
      for (int i = 0; i < wait_n; i++) begin
         @(negedge clk);
         chk("req_hold", {31'd0, fit_req}, 32'd1);
      end
      fit_ack = 1'b1;
      fit_ok  = ok;
      ack_cyc = cyc;
      if (ok) begin
         push(K_MD | K_GR, cyc + 1);
         if (soft_drop_held && exp_rows < 31) exp_rows++;
      end
      @(negedge clk);
      fit_ack = 1'b0;
      fit_ok  = 1'b0;
      chk("req_drop", {31'd0, fit_req}, 32'd0);
   endtask

   task automatic move_recheck(input bit ok);
      piece_moved = 1'b1;
      @(negedge clk);
      piece_moved = 1'b0;
      chk("recheck_req", {31'd0, fit_req}, 32'd1);
      fit_ack = 1'b1;
      fit_ok  = ok;
      ack_cyc = cyc;
      if (ok) push(K_MD | K_GR, cyc + 1);
      @(negedge clk);
      fit_ack = 1'b0;
      fit_ok  = 1'b0;
      chk("recheck_drop", {31'd0, fit_req}, 32'd0);
   endtask

   initial begin
      cyc            = 0;
      checks         = 0;
      errors         = 0;
      exp_rows       = 0;
      rst_n          = 1'b0;
      spawn_valid    = 1'b0;
      down_signal    = 1'b0;
      soft_drop_held = 1'b0;
      piece_moved    = 1'b0;
      fit_ack        = 1'b0;
      fit_ok         = 1'b0;
`ifdef PIECE_FALL_HARD_DROP_EN
      hard_drop      = 1'b0;
`endif

      // Reset state
      @(negedge clk);
      chk("rst_fit_req", {31'd0, fit_req}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rows", {27'd0, drop_rows}, 32'd0);
      chk("rst_md", {31'd0, move_down}, 32'd0);
      chk("rst_lp", {31'd0, lock_piece}, 32'd0);
      chk("rst_gr", {31'd0, gravity_restart}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_busy", {31'd0, busy}, 32'd0);

      // Basic fall: ack after 2 cycles, fit_req high 3 cycles
      spawn();
      fall(2, 1'b1);
      chk("rows_no_soft", {27'd0, drop_rows}, 32'd0);
      chk("busy_wait", {31'd0, busy}, 32'd1);

      // Ignored inputs while in WAIT_TICK
      @(negedge clk);
      spawn_valid = 1'b1;
      fit_ack     = 1'b1;
      fit_ok      = 1'b1;
      piece_moved = 1'b1;
      @(negedge clk);
      spawn_valid = 1'b0;
      fit_ack     = 1'b0;
      fit_ok      = 1'b0;
      piece_moved = 1'b0;
      @(negedge clk);
      chk("ignored_req", {31'd0, fit_req}, 32'd0);

      // Three soft-drop rows
      soft_drop_held = 1'b1;
      for (int i = 0; i < 3; i++) fall(0, 1'b1);
      soft_drop_held = 1'b0;
      chk("rows_soft3", {27'd0, drop_rows}, exp_rows);

      // Blocked, no moves: lock after 4 cycles, then idle
      fall(1, 1'b0);
      push(K_LP, ack_cyc + 5);
      repeat (4) @(negedge clk);
      chk("busy_lock", {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk("busy_after_lock", {31'd0, busy}, 32'd0);
      exp_rows = 0;
      spawn();
      chk("rows_cleared", {27'd0, drop_rows}, exp_rows);

      // Lock restarts limited to MAX_RESETS
      fall(0, 1'b0);
      move_recheck(1'b0);
      move_recheck(1'b0);
      push(K_LP, ack_cyc + 5);
      piece_moved = 1'b1;
      @(negedge clk);
      piece_moved = 1'b0;
      chk("third_move_ign", {31'd0, fit_req}, 32'd0);
      repeat (4) @(negedge clk);
      chk("busy_lock2", {31'd0, busy}, 32'd0);

      // piece_moved on the zero-count cycle wins
      spawn();
      fall(0, 1'b0);
      repeat (3) @(negedge clk);
      move_recheck(1'b1);
      chk("busy_after_win", {31'd0, busy}, 32'd1);

      // Async reset mid-handshake
      @(negedge clk);
      @(negedge clk);
      down_signal = 1'b1;
      @(negedge clk);
      down_signal = 1'b0;
      chk("req_pre_rst", {31'd0, fit_req}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("req_async_rst", {31'd0, fit_req}, 32'd0);
      chk("busy_async_rst", {31'd0, busy}, 32'd0);
      @(negedge clk);
      fit_ack = 1'b1;
      fit_ok  = 1'b1;
      @(negedge clk);
      fit_ack = 1'b0;
      fit_ok  = 1'b0;
      rst_n   = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_post_rst", {31'd0, busy}, 32'd0);
      chk("req_post_rst", {31'd0, fit_req}, 32'd0);

`ifdef PIECE_FALL_HARD_DROP_EN
      // Hard drop: five rows then immediate lock
      spawn();
      @(negedge clk);
      hard_drop = 1'b1;
      @(negedge clk);
      hard_drop = 1'b0;
      chk("hard_req", {31'd0, fit_req}, 32'd1);
      for (int i = 0; i < 6; i++) begin
         fit_ack = 1'b1;
         fit_ok  = (i < 5);
         push((i < 5) ? K_MD : K_LP, cyc + 1);
         @(negedge clk);
      end
      fit_ack = 1'b0;
      fit_ok  = 1'b0;
      chk("hard_rows", {27'd0, drop_rows}, 32'd5);
      chk("hard_req_drop", {31'd0, fit_req}, 32'd0);
      repeat (3) @(negedge clk);
`endif

      repeat (8) @(negedge clk);
      checks++;
      assert (exp_q.size() == 0) else begin
         errors++;
         $error("FAIL pending_events got %0d want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/piece_fall_ctrl.md
Name: piece_fall_ctrl

Overview:
Consumer end of the gravity tick. It takes the gravity generator's down pulse and turns it into a fit-check handshake with the board. On success it issues a one-row move. On a blocked move it runs a lock delay and then commits the piece. After every accepted move it sends a restart pulse back to the gravity generator, so the next fall interval starts fresh.

Parameters:
LOCK_CYCLES, 25_000_000, lock-delay length in clk cycles (0.5 s at 50 MHz); must be ≥1
MAX_RESETS, 15, maximum lock-delay restarts caused by piece_moved per piece
ROW_CNT_W, 5, width of drop_rows

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
spawn_valid  input  1  pulse: new piece placed on board
down_signal  input  1  gravity tick from generator (level, held until restart)
soft_drop_held  input  1  player holding soft drop
piece_moved  input  1  pulse: lateral move/rotate accepted by board
fit_req  output  1  request board to test piece one row lower
fit_ack  input  1  board response valid (one cycle)
fit_ok  input  1  qualified by fit_ack: lower position is free
move_down  output  1  pulse: commit one-row descent
lock_piece  output  1  pulse: piece is fixed, spawn next
gravity_restart  output  1  pulse: restart gravity counter
busy  output  1  high in any state except IDLE
drop_rows  output  ROW_CNT_W  rows descended with soft drop held, current piece

Behaviour:
- Reset (async, rst_n=0): state IDLE; all pulse outputs 0; fit_req 0; busy 0; drop_rows 0; lock counter 0; reset counter 0.
- IDLE:
  - spawn_valid=1 → WAIT_TICK.
  - gravity_restart pulses the next cycle.
  - drop_rows and the reset counter clear.
- WAIT_TICK:
  - down_signal=1 → CHECK.
  - fit_req rises the cycle after down_signal is seen.
- CHECK:
  - fit_req is held high until the cycle fit_ack=1, then drops the following cycle.
  - fit_ack with fit_ok=1:
    - move_down and gravity_restart pulse together, 1 cycle after ack.
    - drop_rows increments if soft_drop_held (saturating at all-ones).
    - → WAIT_TICK.
  - fit_ack with fit_ok=0: load the lock counter with LOCK_CYCLES-1 → LOCK_WAIT.
- LOCK_WAIT:
  - The counter decrements each cycle.
  - piece_moved=1 with reset count < MAX_RESETS: increment the reset count → CHECK (re-test; the piece may now fall).
  - Counter==0 and no eligible piece_moved: lock_piece pulses one cycle → IDLE.
  - Simultaneous piece_moved and counter==0: piece_moved wins if resets remain.
  - down_signal is ignored in LOCK_WAIT.
- Boundary rules:
  - spawn_valid outside IDLE: ignored.
  - fit_ack while fit_req=0: ignored.
  - piece_moved outside LOCK_WAIT: ignored.
  - rst_n asserted mid-handshake: fit_req drops immediately (async); no move_down or lock_piece is emitted.
- Latency: down_signal→fit_req is 1 cycle; fit_ack→move_down is 1 cycle; lock counter load→lock_piece is LOCK_CYCLES cycles.
- Width rules:
  - Lock counter is $clog2(LOCK_CYCLES) bits, minimum 1.
  - Reset counter is $clog2(MAX_RESETS+1) bits.
- Outputs are registered. No combinational path from any input to any output.

Optional Feature:
- Macro: PIECE_FALL_HARD_DROP_EN.
- With the macro:
  - Adds input hard_drop (pulse), accepted in WAIT_TICK or LOCK_WAIT → CHECK.
  - In hard mode each fit_ok re-issues fit_req immediately, without waiting for down_signal.
  - move_down still pulses once per row, and drop_rows counts every row regardless of soft_drop_held.
  - The first fit_ok=0 gives lock_piece the cycle after ack, with no lock delay.
  - gravity_restart is suppressed until lock.
- Without the macro: the port is absent and behaviour is exactly as above.

Decomposition:
- tetris_pkg holds:
  - enum fall_state_t {IDLE, WAIT_TICK, CHECK, LOCK_WAIT, LOCK}
  - constant CLK_HZ = 50_000_000
  - default LOCK_CYCLES/MAX_RESETS constants
- Sub-module lock_timer is natural: load/decrement/zero-flag counter, parameter CYCLES.

Test Plan (LOCK_CYCLES=4, MAX_RESETS=2):
- spawn_valid; down_signal; fit_ack/fit_ok=1 after 2 cycles → fit_req high 3 cycles; one move_down plus gravity_restart 1 cycle after ack; back in WAIT_TICK.
- Three ticks with fit_ok=1 while soft_drop_held=1 → drop_rows=3. Next spawn → drop_rows=0.
- Tick, fit_ok=0, no piece_moved → lock_piece exactly 4 cycles after ack-state exit; busy=0 the next cycle.
- Blocked; piece_moved ×3, each before timeout, with every re-check fit_ok=0 → first two restart the lock; third ignored; lock_piece 4 cycles after the second restart.
- piece_moved on the same cycle counter==0 (resets remaining) → no lock_piece; fit_req asserts; re-check fit_ok=1 → move_down.
- rst_n low while fit_req=1 → fit_req=0 asynchronously; no pulses; IDLE after release.
- With PIECE_FALL_HARD_DROP_EN: hard_drop, board fit_ok=1 ×5 then 0 → 5 move_down pulses, drop_rows=5, lock_piece 1 cycle after final ack.
